// File: rtl/kims123_pkg.sv
// Shared definitions for the kims123 accumulator core: opcodes, flag
// bit positions within uio_out, and the fixed bidirectional-pin enables.
package kims123_pkg;

    // Operation selected by uio_in[2:0].
    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_SHL  = 3'b110,
        OP_SHR  = 3'b111
    } opcode_e;

    // Flag bit positions on uio_out.
    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_C = 5;
    localparam int FLAG_V = 4;

    // Upper nibble of the bidirectional pins drives flags, lower nibble is input.
    localparam logic [7:0] UIO_OE = 8'hF0;

    // Bit position of the exec strobe on uio_in.
    localparam int EXEC_BIT = 3;

    // Assemble the flag byte presented on uio_out.
    function automatic logic [7:0] pack_flags(input logic z, input logic n,
                                              input logic c, input logic v);
        logic [7:0] flags;
        flags         = '0;
        flags[FLAG_Z] = z;
        flags[FLAG_N] = n;
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
        return flags;
    endfunction

endpackage

// File: rtl/kims123_alu.sv
// Purely combinational ALU: computes the next accumulator value together
// with the carry/borrow and signed-overflow flags for one operation.
module kims123_alu
    import kims123_pkg::*;
(
    input  logic [7:0] acc,
    input  logic [7:0] b,
    input  opcode_e    op,
    output logic [7:0] result,
    output logic       c,
    output logic       v
);

    logic [8:0] sum9;
    logic [8:0] diff9;

    // Evaluate the selected operation and its flags.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves it unassigned, which would infer a latch.
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        // The ninth bit of the widened difference is set exactly when acc < b.
        sum9   = {1'b0, acc} + {1'b0, b};
        diff9  = {1'b0, acc} - {1'b0, b};

        case (op)
            OP_LOAD: result = b;
            OP_ADD: begin
                result = sum9[7:0];
                c      = sum9[8];
                v      = (acc[7] == b[7]) && (sum9[7] != acc[7]);
            end
            OP_SUB: begin
                result = diff9[7:0];
                c      = diff9[8];
                v      = (acc[7] != b[7]) && (diff9[7] != acc[7]);
            end
            OP_AND:  result = acc & b;
            OP_OR:   result = acc | b;
            OP_XOR:  result = acc ^ b;
            OP_SHL: begin
                result = {acc[6:0], 1'b0};
                c      = acc[7];
            end
            OP_SHR: begin
                result = {1'b0, acc[7:1]};
                c      = acc[0];
            end
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/tt_um_giffel1_kims123_core.sv
// Accumulator core: holds ACC, C and V, executes one ALU operation per
// clock while enabled and strobed, and maps state onto the TinyTapeout pins.
// rst_n is active-high and synchronous despite its name.
module tt_um_giffel1_kims123_core
    import kims123_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [7:0] acc_q;
    logic       c_q;
    logic       v_q;

    logic [7:0] alu_result;
    logic       alu_c;
    logic       alu_v;
    logic       exec;
    opcode_e    op;

    assign exec = uio_in[EXEC_BIT];
    assign op   = opcode_e'(uio_in[2:0]);

    // uio_in[7:4] carry no function; gathered here so they are visibly consumed.
    logic unused_uio_hi;
    assign unused_uio_hi = &{1'b0, uio_in[7:4]};

    kims123_alu u_alu (
        .acc    (acc_q),
        .b      (ui_in),
        .op     (op),
        .result (alu_result),
        .c      (alu_c),
        .v      (alu_v)
    );

    // Accumulator and flag registers: reset wins, otherwise update only on executing cycles.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values together.
        if (rst_n) begin
            acc_q <= '0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
        end else if (ena && exec) begin
            acc_q <= alu_result;
            c_q   <= alu_c;
            v_q   <= alu_v;
        end
    end

    // Output mapping: Z and N derive directly from ACC, C and V come from registers.
    always_comb begin
        uo_out  = acc_q;
        uio_out = pack_flags(acc_q == 8'h00, acc_q[7], c_q, v_q);
        uio_oe  = UIO_OE;
    end

endmodule

// File: tb/tb_tt_um_giffel1_kims123_core.sv
// Scoreboard bench: the stimulus process drives one cycle at a time and
// pushes the expected pin values from an arithmetic reference model; an
// independent monitor pops and compares after every rising edge.
module tb_tt_um_giffel1_kims123_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic [7:0] ui_in = '0;
    logic [7:0] uio_in = '0;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      name;
        logic [7:0] uo;
        logic [7:0] uio;
    } exp_t;

    exp_t sb[$];

    // Reference model state, kept as plain integers.
    int m_acc = 0;
    int m_c   = 0;
    int m_v   = 0;

    tt_um_giffel1_kims123_core dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    function automatic int to_signed(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    // Apply the operation rules to the model state.
    task automatic model_exec(input int op, input int b);
        int s;
        case (op)
            0: begin m_acc = b; m_c = 0; m_v = 0; end
            1: begin
                s     = to_signed(m_acc) + to_signed(b);
                m_v   = (s > 127 || s < -128) ? 1 : 0;
                m_c   = (m_acc + b > 255) ? 1 : 0;
                m_acc = (m_acc + b) % 256;
            end
            2: begin
                s     = to_signed(m_acc) - to_signed(b);
                m_v   = (s > 127 || s < -128) ? 1 : 0;
                m_c   = (m_acc < b) ? 1 : 0;
                m_acc = (m_acc - b + 256) % 256;
            end
            3: begin m_acc = m_acc & b; m_c = 0; m_v = 0; end
            4: begin m_acc = m_acc | b; m_c = 0; m_v = 0; end
            5: begin m_acc = m_acc ^ b; m_c = 0; m_v = 0; end
            6: begin m_c = (m_acc >= 128) ? 1 : 0; m_acc = (m_acc * 2) % 256; m_v = 0; end
            default: begin m_c = m_acc % 2; m_acc = m_acc / 2; m_v = 0; end
        endcase
    endtask

    // Drive one cycle of inputs and queue the pin values expected after the next edge.
    task automatic step(input logic r, input logic e, input logic x, input int op,
                        input int b, input int noise, input string name);
        exp_t ex;
        @(negedge clk);
        rst_n  = r;
        ena    = e;
        ui_in  = 8'(b);
        uio_in = {4'(noise), x, 3'(op)};
        if (r) begin
            m_acc = 0; m_c = 0; m_v = 0;
        end else if (e && x) begin
            model_exec(op, b);
        end
        ex.name = name;
        ex.uo   = 8'(m_acc);
        ex.uio  = {(m_acc == 0) ? 1'b1 : 1'b0, (m_acc >= 128) ? 1'b1 : 1'b0,
                   1'(m_c), 1'(m_v), 4'b0000};
        sb.push_back(ex);
    endtask

    task automatic op_step(input int op, input int b, input string name);
        step(1'b0, 1'b1, 1'b1, op, b, 0, name);
    endtask

    // Monitor: outputs are valid every cycle, so compare after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".uo_out"}, uo_out, e.uo);
                check({e.name, ".uio_out"}, uio_out, e.uio);
                check({e.name, ".uio_oe"}, uio_oe, 8'hF0);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset, then idle.
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, "reset");
        step(1'b0, 1'b1, 1'b0, 0, 0, 0, "idle0");
        step(1'b0, 1'b1, 1'b0, 1, 8'h33, 4'hF, "idle1");

        // Signed overflow into negative.
        op_step(0, 8'h7F, "load7f");
        op_step(1, 8'h01, "add_ovf");

        // Borrow, then carry wrapping to zero.
        op_step(0, 8'h05, "load05");
        op_step(2, 8'h06, "sub_borrow");
        op_step(1, 8'h01, "add_wrap");

        // Shifts and XOR.
        op_step(0, 8'h81, "load81");
        op_step(6, 8'h00, "shl");
        op_step(7, 8'h00, "shr");
        op_step(5, 8'hFF, "xor");

        // Establish C=1, V=1, then verify both hold conditions.
        op_step(0, 8'h00, "load00");
        op_step(2, 8'h80, "sub_ovf");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1, 8'h11, 0, "hold_ena0");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 6, 8'h22, 0, "hold_exec0");

        // Upper uio_in bits must not matter.
        step(1'b0, 1'b1, 1'b1, 0, 8'hA5, 4'hF, "noise_load");
        step(1'b0, 1'b1, 1'b1, 1, 8'h5A, 4'h9, "noise_add");

        // Reset beats a simultaneous ADD.
        op_step(0, 8'h55, "load55");
        step(1'b1, 1'b1, 1'b1, 1, 8'h01, 0, "reset_over_exec");
        step(1'b0, 1'b1, 1'b0, 0, 0, 0, "after_reset");

        // Exec held high repeats the operation.
        op_step(0, 8'h01, "load01");
        for (int i = 0; i < 4; i++) op_step(1, 8'h40, "repeat_add");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 5) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 15)), "random");
        end

        // Let the monitor drain the scoreboard.
        repeat (3) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tt_um_giffel1_kims123_core.md
TT_UM_GIFFEL1_KIMS123_CORE -- requirements
Module: tt_um_giffel1_kims123

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  synchronous reset; rst_n=1 resets on the next clk edge (active-high despite the TinyTapeout port name).
REQ-004 ena  input  1  enable; 0 = all registers hold.
REQ-005 ui_in  input  8  operand B.
REQ-006 uio_in  input  8  [2:0] opcode, [3] exec strobe (level), [7:4] ignored.
REQ-007 uo_out  output  8  accumulator ACC.
REQ-008 uio_out  output  8  [7]=Z, [6]=N, [5]=C, [4]=V; [3:0]=0.
REQ-009 uio_oe  output  8  constant 8'hF0.

Function
REQ-010 SHALL execute one operation per rising clk edge when ena=1, uio_in[3]=1 and reset is not asserted; exec held high repeats the operation every cycle.
REQ-011 SHALL make the result visible on uo_out/uio_out one cycle after the executing edge; there is no handshake or busy state.
REQ-012 Opcodes: 000 LOAD ACC=B; 001 ADD ACC+B; 010 SUB ACC-B; 011 AND; 100 OR; 101 XOR; 110 SHL ACC<<1; 111 SHR logical ACC>>1.
REQ-013 Arithmetic SHALL be 8-bit modulo 256.
REQ-014 C SHALL be the carry-out for ADD and the borrow for SUB (C=1 iff ACC<B unsigned); C=ACC[7] before SHL; C=ACC[0] before SHR; C=0 for LOAD and logic ops.
REQ-015 V SHALL be the two's-complement signed overflow for ADD and SUB; V=0 for all other ops.
REQ-016 C and V SHALL be registered and SHALL update only on executing cycles.
REQ-017 Z=(ACC==0) and N=ACC[7] SHALL be combinational from ACC.
REQ-018 With exec=0 or ena=0, ACC, C and V SHALL hold.
REQ-019 Reset SHALL take priority over ena and exec when asserted in the same cycle.
REQ-020 uio_in[7:4] SHALL have no effect.

Reset
REQ-021 On reset: ACC=0x00, C=0, V=0; outputs then show uo_out=0x00, uio_out=0x80 (Z=1), uio_oe=0xF0.
REQ-022 Reset asserted mid-sequence SHALL discard the in-flight operation; no partial update.

Structure
REQ-023 Package kims123_pkg SHALL hold the opcode enumeration, the flag bit-position constants, and the UIO_OE constant 8'hF0.
REQ-024 A combinational sub-module kims123_alu SHALL take ACC, B and opcode and return the result, C and V; the top SHALL hold the registers and I/O mapping.

Verification
REQ-025 Reset, then idle -> uo_out=0x00, uio_out=0x80, uio_oe=0xF0.
REQ-026 LOAD 0x7F, then ADD 0x01 -> uo_out=0x80; flags N=1, V=1, C=0, Z=0 (uio_out=0x50).
REQ-027 LOAD 0x05, then SUB 0x06 -> uo_out=0xFF with N=1 and C=1; then ADD 0x01 -> uo_out=0x00 with Z=1 and C=1.
REQ-028 LOAD 0x81, then SHL -> 0x02 with C=1; SHR -> 0x01 with C=0; XOR 0xFF -> 0xFE with C=0.
REQ-029 exec=1 with ena=0, and separately ena=1 with exec=0, for 3 cycles -> ACC and flags unchanged.
REQ-030 LOAD 0x55, then assert reset with exec=1 and opcode ADD -> next cycle uo_out=0x00, uio_out=0x80.
